// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus width and memory-interface FSM state encoding.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2,
    MEM_DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for RAM transactions; expire flags the last permitted wait cycle.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturates at TIMEOUT-1 so an unattended counter never wraps back to zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_interface.sv
// MAR/MDR registers and RAM read/write handshake with variable-latency ack and timeout.
module mem_bus_interface #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mari,
  input  logic              mdri,
  input  logic              mdro,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] mdr_bus,
  output logic [DATA_W-1:0] mar_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  import cpu_pkg::*;

  mem_state_t        state;
  logic [DATA_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              rd_last;
  logic              in_wait;
  logic              accept;
  logic              expire;

  assign in_wait = (state == MEM_RD_WAIT) || (state == MEM_WR_WAIT);
  assign accept  = !in_wait && (rd_req || wr_req);

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .enable(in_wait && !mem_ack),
    .expire(expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= MEM_IDLE;
      mar     <= '0;
      mdr     <= '0;
      rd_last <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mari && !in_wait) begin
        mar <= bus_in;
      end
      // Read data captured on the ack edge wins over a bus load in the following DONE cycle.
      if (mdri && !in_wait && !(state == MEM_DONE && rd_last)) begin
        mdr <= bus_in;
      end
      case (state)
        MEM_IDLE, MEM_DONE: begin
          if (rd_req) begin
            state  <= MEM_RD_WAIT;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
            err    <= 1'b0;
          end else if (wr_req) begin
            state  <= MEM_WR_WAIT;
            mem_wr <= 1'b1;
            busy   <= 1'b1;
            err    <= 1'b0;
          end else begin
            state <= MEM_IDLE;
          end
        end
        MEM_RD_WAIT: begin
          if (mem_ack) begin
            mdr     <= mem_rdata;
            state   <= MEM_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            mem_rd  <= 1'b0;
            rd_last <= 1'b1;
          end else if (expire) begin
            state  <= MEM_IDLE;
            err    <= 1'b1;
            busy   <= 1'b0;
            mem_rd <= 1'b0;
          end
        end
        MEM_WR_WAIT: begin
          if (mem_ack) begin
            state   <= MEM_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            mem_wr  <= 1'b0;
            rd_last <= 1'b0;
          end else if (expire) begin
            state  <= MEM_IDLE;
            err    <= 1'b1;
            busy   <= 1'b0;
            mem_wr <= 1'b0;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  assign mar_q     = mar;
  assign mem_addr  = mar[ADDR_W-1:0];
  assign mem_wdata = mdr;
  assign mdr_bus   = mdro ? mdr : '0;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Scoreboard bench for mem_bus_interface: RAM responder, reference memory, decoupled monitor.
module tb_mem_bus_interface;

  localparam int unsigned TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_in;
  logic        mari, mdri, mdro, rd_req, wr_req;
  logic [31:0] mdr_bus, mar_q, mem_wdata, mem_rdata;
  logic        busy, done, err, mem_rd, mem_wr, mem_ack;
  logic [8:0]  mem_addr;

  mem_bus_interface #(
    .ADDR_W (9),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus_in   (bus_in),
    .mari     (mari),
    .mdri     (mdri),
    .mdro     (mdro),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .mdr_bus  (mdr_bus),
    .mar_q    (mar_q),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          timeout;
    bit          is_read;
    logic [31:0] data;
    logic [8:0]  addr;
    int          rd_n;
    int          wr_n;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ram[512];
  logic [31:0] ref_mem[512];
  logic [31:0] mar_m, mdr_m;
  int          errors = 0;
  int          checks = 0;
  int          completions = 0;
  int          ack_lat = 1;
  bit          resp_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // RAM model: acks after ack_lat strobe cycles (0 = never), stores writes at ack.
  initial begin : responder
    int scnt;
    scnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (resp_en) begin
        if (mem_rd || mem_wr) begin
          scnt++;
          if (ack_lat != 0 && scnt == ack_lat) begin
            mem_ack = 1'b1;
            mem_rdata = ram[mem_addr];
            if (mem_wr) ram[mem_addr] = mem_wdata;
          end else begin
            mem_ack = 1'b0;
            mem_rdata = $urandom();
          end
        end else begin
          scnt = 0;
          mem_ack = 1'b0;
          mem_rdata = $urandom();
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each done pulse or rising err.
  initial begin : monitor
    int          rd_cyc, wr_cyc;
    bit          unstable, err_prev, done_prev;
    logic [8:0]  cap_addr;
    logic [31:0] cap_wdata;
    exp_t        e;
    rd_cyc = 0; wr_cyc = 0; unstable = 0; err_prev = 0; done_prev = 0;
    cap_addr = '0; cap_wdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        rd_cyc = 0; wr_cyc = 0; unstable = 0; err_prev = 0; done_prev = 0;
      end else begin
        if (mem_rd || mem_wr) begin
          if (rd_cyc + wr_cyc == 0) begin
            cap_addr = mem_addr;
            cap_wdata = mem_wdata;
          end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata) begin
            unstable = 1'b1;
          end
        end
        if (mem_rd) rd_cyc++;
        if (mem_wr) wr_cyc++;
        if (done || (err && !err_prev)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("completion_kind", {31'd0, err && !done}, {31'd0, e.timeout});
            check("rd_strobe_cycles", rd_cyc, e.rd_n);
            check("wr_strobe_cycles", wr_cyc, e.wr_n);
            check("strobe_stable", {31'd0, unstable}, 32'd0);
            check("busy_after", {31'd0, busy}, 32'd0);
            if (!e.timeout) begin
              check("mem_addr", {23'd0, mem_addr}, {23'd0, e.addr});
              if (e.is_read) check("read_data", mdr_bus, e.data);
              else           check("write_data", mem_wdata, e.data);
            end else begin
              check("mdr_after_timeout", mdr_bus, e.data);
            end
          end
          rd_cyc = 0; wr_cyc = 0; unstable = 0;
          completions++;
        end
        if (done && done_prev) check("done_one_cycle", 32'd1, 32'd0);
        err_prev = err;
        done_prev = done;
      end
    end
  end

  task automatic load_mar(input logic [31:0] v);
    bus_in = v; mari = 1'b1;
    cyc();
    mari = 1'b0;
    mar_m = v;
    @(negedge clock);
    check("mar_load", mar_q, v);
    cyc();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    bus_in = v; mdri = 1'b1;
    cyc();
    mdri = 1'b0;
    mdr_m = v;
    @(negedge clock);
    check("mdr_load", mdr_bus, v);
    cyc();
  endtask

  // Reference behaviour: read wins over write; lat 0 means timeout with no state change.
  task automatic start(input bit rd, input bit wr, input int lat);
    exp_t e;
    e.timeout = (lat == 0);
    e.is_read = rd;
    e.addr = mar_m[8:0];
    if (rd) begin
      e.rd_n = (lat == 0) ? TIMEOUT : lat;
      e.wr_n = 0;
      if (lat != 0) mdr_m = ref_mem[e.addr];
    end else begin
      e.rd_n = 0;
      e.wr_n = (lat == 0) ? TIMEOUT : lat;
      if (lat != 0) ref_mem[e.addr] = mdr_m;
    end
    e.data = mdr_m;
    exp_q.push_back(e);
    ack_lat = lat;
    rd_req = rd; wr_req = wr;
    cyc();
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clock);
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_clears_err", {31'd0, err}, 32'd0);
    cyc();
  endtask

  task automatic wait_done(input int c0);
    for (int i = 0; i < 60 && completions == c0; i++) cyc();
    check("completion_seen", {31'd0, completions != c0}, 32'd1);
    cyc();
  endtask

  task automatic txn(input bit rd, input bit wr, input int lat);
    int c0;
    c0 = completions;
    start(rd, wr, lat);
    wait_done(c0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c0;
    bus_in = '0; mari = 0; mdri = 0; mdro = 1; rd_req = 0; wr_req = 0;
    mar_m = '0; mdr_m = '0;
    for (int i = 0; i < 512; i++) begin
      ram[i] = $urandom();
      ref_mem[i] = ram[i];
    end
    ram[9'h014] = 32'hDEADBEEF;
    ref_mem[9'h014] = 32'hDEADBEEF;

    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clock);
    check("reset_mar", mar_q, 32'd0);
    check("reset_mdr", mdr_bus, 32'd0);
    check("reset_flags", {27'd0, busy, done, err, mem_rd, mem_wr}, 32'd0);
    cyc();

    load_mar(32'h0000_0014);
    txn(1, 0, 3);
    mdro = 1'b0;
    #1 check("mdro_gate", mdr_bus, 32'd0);
    mdro = 1'b1;

    load_mar(32'h0000_01FF);
    load_mdr(32'h1234_5678);
    txn(0, 1, 1);
    check("ram_written", ram[9'h1FF], 32'h1234_5678);
    load_mdr(32'h0);
    txn(1, 0, 2);

    load_mar(32'h0000_0077);
    txn(1, 1, 2);

    txn(1, 0, 0);
    @(negedge clock);
    check("err_sticky", {31'd0, err}, 32'd1);
    cyc();
    txn(1, 0, 1);

    // mdri in the DONE cycle of a read must not overwrite the read data
    load_mar(32'h0000_0033);
    c0 = completions;
    start(1, 0, 1);
    bus_in = 32'hFFFF_FFFF; mdri = 1'b1;
    cyc();
    mdri = 1'b0;
    wait_done(c0);
    check("mdri_ignored_done", mdr_bus, ref_mem[9'h033]);

    // bus loads during a write wait are ignored
    load_mar(32'hA5A5_0155);
    load_mdr(32'h600D_CAFE);
    c0 = completions;
    start(0, 1, 4);
    bus_in = 32'hFFFF_FFFF; mari = 1'b1; mdri = 1'b1;
    cyc();
    mari = 1'b0; mdri = 1'b0;
    wait_done(c0);
    check("mari_ignored_wait", mar_q, 32'hA5A5_0155);
    check("mdri_ignored_wait", mem_wdata, 32'h600D_CAFE);

    // reset in the second read-wait cycle, then a stray ack
    load_mar(32'h0000_0044);
    start(1, 0, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    mar_m = '0; mdr_m = '0;
    @(negedge clock);
    check("midreset_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("midreset_mar", mar_q, 32'd0);
    check("midreset_mdr", mdr_bus, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    resp_en = 1'b0;
    cyc();
    mem_rdata = 32'hCAFE_F00D; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    @(negedge clock);
    check("stray_ack_ignored", mdr_bus, 32'd0);
    check("stray_ack_no_done", {30'd0, done, busy}, 32'd0);
    resp_en = 1'b1;
    cyc();

    for (int n = 0; n < 30; n++) begin
      int kind, lat;
      load_mar($urandom());
      if ($urandom_range(0, 1) == 1) load_mdr($urandom());
      kind = $urandom_range(0, 2);
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      txn(kind != 1, kind != 0, lat);
    end

    repeat (3) cyc();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_interface.md
Name: mem_bus_interface

Overview:
Memory address/data interface between the shared 32-bit CPU bus and word-addressed instruction/data RAM. It holds the MAR and MDR registers and runs the read/write handshake to RAM with variable-latency acknowledge. Upstream of the control FSM, it supplies fetched instruction words that the control unit loads into the IR. It also reports completion so the control FSM knows when to advance out of its fetch/load/store wait states.

Parameters:
ADDR_W, 9, RAM word-address width; MAR low ADDR_W bits drive mem_addr
DATA_W, 32, bus/MDR/RAM data width
TIMEOUT, 15, max cycles waiting for mem_ack before error (1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
bus_in  in  DATA_W  shared CPU bus value
mari  in  1  load MAR from bus_in (MAR in)
mdri  in  1  load MDR from bus_in (MDR in)
mdro  in  1  MDR output enable; gates mdr_bus
rd_req  in  1  start RAM read at MAR, result into MDR
wr_req  in  1  start RAM write of MDR to MAR
mdr_bus  out  DATA_W  MDR when mdro=1, else 0
mar_q  out  DATA_W  MAR contents
busy  out  1  transaction in progress
done  out  1  one-cycle pulse when transaction completes
err  out  1  sticky timeout flag, cleared by reset or the next accepted request
mem_addr  out  ADDR_W  MAR[ADDR_W-1:0]
mem_wdata  out  DATA_W  MDR contents
mem_rd  out  1  RAM read strobe, held until ack
mem_wr  out  1  RAM write strobe, held until ack
mem_rdata  in  DATA_W  RAM read data, valid with mem_ack
mem_ack  in  1  RAM completion, one cycle

Behaviour:
- Reset: MAR=0, MDR=0, state IDLE, timeout counter 0; busy, done, err, mem_rd, mem_wr all 0. Reset takes effect mid-transaction and drops strobes the next cycle.
- States:
  - IDLE: no transaction.
  - RD_WAIT: mem_rd=1, busy=1.
  - WR_WAIT: mem_wr=1, busy=1.
  - DONE: done=1 for one cycle, busy=0.
- IDLE + rd_req -> RD_WAIT. IDLE + wr_req -> WR_WAIT. rd_req and wr_req together -> read wins; the write is ignored, not queued.
- Requests are accepted only in IDLE or DONE. Requests in RD_WAIT/WR_WAIT are ignored. Request in DONE -> same transitions as IDLE, so back-to-back transactions are possible.
- Accepting a request clears err and zeroes the counter.
- RD_WAIT + mem_ack: MDR <= mem_rdata on that edge -> DONE. Minimum latency: request cycle N, strobe visible N+1, ack at N+1 gives done at N+2 with MDR valid.
- WR_WAIT + mem_ack -> DONE. mem_wdata/mem_addr stay stable while the strobe is high.
- Timeout: counter increments each wait cycle without ack. At count==TIMEOUT-1 with no ack: err<=1, strobe drops, -> IDLE, no done pulse. Ack on that same cycle completes normally.
- mem_ack outside a wait state is ignored.
- MAR/MDR bus loads:
  - mari loads MAR from bus_in in any state except RD_WAIT/WR_WAIT, where it is ignored.
  - mdri behaves the same, except that in the DONE cycle of a read, RAM data already written takes priority and mdri that cycle is ignored.
  - MAR keeps all DATA_W bits; only mem_addr is truncated.
- mdr_bus is combinational from MDR and mdro, and reflects a read result from the DONE cycle onward.
- Counter width: $clog2(TIMEOUT+1).

Decomposition:
- Shared package cpu_pkg: DATA_W constant, memory FSM state encoding (IDLE=2'd0, RD_WAIT=1, WR_WAIT=2, DONE=3).
- One natural sub-module: mem_timeout_counter (clear, enable, expire output, parameter TIMEOUT).
- MAR/MDR registers stay inline.

Test Plan:
- Reset, then mari with bus_in=0x00000014, rd_req; RAM model acks after 3 cycles with 0xDEADBEEF -> mem_addr=0x014, mem_rd high 3 cycles, done pulse one cycle, mdro gives mdr_bus=0xDEADBEEF.
- Write path: MAR=0x1FF, mdri bus_in=0x12345678, wr_req, ack after 1 cycle -> mem_wr one cycle, mem_wdata=0x12345678, done pulse; RAM[0x1FF]=0x12345678.
- Simultaneous rd_req+wr_req -> only mem_rd asserted; mem_wr stays 0 throughout.
- No ack (TIMEOUT=15) -> mem_rd high 15 cycles, then err=1, no done, state IDLE. Next rd_req clears err.
- Reset asserted in RD_WAIT cycle 2 -> strobe 0, MAR/MDR 0, busy 0 next cycle. A late ack is ignored and MDR stays 0.
- mari/mdri pulsed during WR_WAIT with bus_in=0xFFFFFFFF -> MAR/MDR unchanged; mem_addr/mem_wdata stable until ack.
